// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for a 5-stage pipe: EX/MEM forwarding selects,
// load-use interlock and a multi-cycle multiplier scoreboard.
module pipe_hazard_ctrl #(
   parameter int REG_AW  = 5,
   parameter int NSRC    = 2,
   parameter int MUL_LAT = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     id_valid,
   input  logic [NSRC*REG_AW-1:0]   id_src,
   input  logic [NSRC-1:0]          id_use,
   input  logic [REG_AW-1:0]        id_rd,
   input  logic                     id_regwrite,
   input  logic                     id_memread,
   input  logic                     id_mul,
   input  logic                     flush,
   output logic                     stall,
   output logic [2*NSRC-1:0]        fwd_sel,
   output logic                     mul_busy
);

   localparam int CW = 4;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              regwrite;
      logic              memread;
   } ent_t;

   typedef enum logic {
      S_IDLE,
      S_BUSY
   } mst_t;

   ent_t              exe_q, exe_d;
   ent_t              mem_q;
   logic [2*NSRC-1:0] fwd_q, fwd_d;
   mst_t              st_q, st_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [REG_AW-1:0] mrd_q, mrd_d;

   logic [NSRC-1:0]   hit_exe, hit_mem, hit_mul;
   logic              lu_stall, mul_stall, adv;

   // A load sitting in EX/MEM is resolved by forwarding, so its memread
   // bit is carried only to keep the entry format uniform.
   logic              unused_mem_memread;
   assign unused_mem_memread = mem_q.memread;

   for (genvar k = 0; k < NSRC; k++) begin : g_src
      logic [REG_AW-1:0] src;
      logic              live;
      assign src  = id_src[k*REG_AW +: REG_AW];
      assign live = id_use[k] & (src != '0);
      assign hit_exe[k] = live & exe_q.valid & exe_q.regwrite
                          & (exe_q.rd == src);
      assign hit_mem[k] = live & mem_q.valid & mem_q.regwrite
                          & (mem_q.rd == src);
      assign hit_mul[k] = live & (mrd_q == src);
      assign fwd_d[2*k +: 2] = !adv       ? 2'b00 :
                               hit_exe[k] ? 2'b10 :
                               hit_mem[k] ? 2'b01 : 2'b00;
   end

   assign lu_stall  = id_valid & exe_q.memread & (|hit_exe);
   assign mul_stall = (st_q == S_BUSY) & id_valid
                      & (id_mul | (|hit_mul));
   assign stall     = rst_n & ~flush & (lu_stall | mul_stall);
   assign adv       = ~stall & ~flush;

   assign exe_d = adv ? {id_valid, id_rd, id_regwrite & ~id_mul,
                         id_memread}
                      : '0;

   always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      mrd_d = mrd_q;
      unique case (st_q)
         S_IDLE: begin
            if (adv & id_valid & id_mul) begin
               st_d  = S_BUSY;
               cnt_d = CW'(MUL_LAT - 1);
               mrd_d = id_rd;
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q - CW'(1);
            // The result lands in the regfile on this edge.
            if (cnt_q == CW'(1)) begin
               st_d  = S_IDLE;
               mrd_d = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exe_q <= '0;
         mem_q <= '0;
         fwd_q <= '0;
         st_q  <= S_IDLE;
         cnt_q <= '0;
         mrd_q <= '0;
      end else begin
         exe_q <= exe_d;
         mem_q <= exe_q;
         fwd_q <= fwd_d;
         st_q  <= st_d;
         cnt_q <= cnt_d;
         mrd_q <= mrd_d;
      end
   end

   assign fwd_sel  = fwd_q;
   assign mul_busy = (st_q == S_BUSY);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scenario bench for pipe_hazard_ctrl.
// Inputs change at negedge; registered outputs are read one negedge later.
module tb_pipe_hazard_ctrl;

   localparam int AW  = 5;
   localparam int NS  = 2;
   localparam int LAT = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             id_valid;
   logic [NS*AW-1:0] id_src;
   logic [NS-1:0]    id_use;
   logic [AW-1:0]    id_rd;
   logic             id_regwrite;
   logic             id_memread;
   logic             id_mul;
   logic             flush;
   logic             stall;
   logic [2*NS-1:0]  fwd_sel;
   logic             mul_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(
      .REG_AW (AW),
      .NSRC   (NS),
      .MUL_LAT(LAT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .id_valid   (id_valid),
      .id_src     (id_src),
      .id_use     (id_use),
      .id_rd      (id_rd),
      .id_regwrite(id_regwrite),
      .id_memread (id_memread),
      .id_mul     (id_mul),
      .flush      (flush),
      .stall      (stall),
      .fwd_sel    (fwd_sel),
      .mul_busy   (mul_busy)
   );

   task automatic set_id(input logic v, input logic [4:0] s1,
                         input logic [4:0] s0, input logic [1:0] u,
                         input logic [4:0] rd, input logic rw,
                         input logic mr, input logic ml,
                         input logic fl);
      id_valid    = v;
      id_src      = {s1, s0};
      id_use      = u;
      id_rd       = rd;
      id_regwrite = rw;
      id_memread  = mr;
      id_mul      = ml;
      flush       = fl;
   endtask

   task automatic nop();
      set_id(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
   endtask

   task automatic drain();
      nop();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      set_id(1, 4, 4, 2'b11, 4, 1, 1, 1, 0);
      #2;
      checks++;
      if (stall !== 1'b0) begin errors++;
         $display("FAIL rst_stall: got %b want 0", stall); end
      checks++;
      if (fwd_sel !== 4'b0000) begin errors++;
         $display("FAIL rst_fwd: got %b want 0000", fwd_sel); end
      checks++;
      if (mul_busy !== 1'b0) begin errors++;
         $display("FAIL rst_busy: got %b want 0", mul_busy); end
      repeat (2) @(negedge clk);
      checks++;
      if (mul_busy !== 1'b0) begin errors++;
         $display("FAIL rst_busy_hold: got %b want 0", mul_busy); end
      checks++;
      if (fwd_sel !== 4'b0000) begin errors++;
         $display("FAIL rst_fwd_hold: got %b want 0000", fwd_sel); end
      nop();
      rst_n = 1'b1;
   endtask

   task automatic test_back_to_back();
      set_id(1, 2, 1, 2'b11, 3, 1, 0, 0, 0);
      #1;
      checks++;
      if (stall !== 1'b0) begin errors++;
         $display("FAIL b2b_stall0: got %b want 0", stall); end
      @(negedge clk);
      checks++;
      if (fwd_sel !== 4'b0000) begin errors++;
         $display("FAIL b2b_fwd0: got %b want 0000", fwd_sel); end
      set_id(1, 3, 3, 2'b11, 5, 1, 0, 0, 0);
      #1;
      checks++;
      if (stall !== 1'b0) begin errors++;
         $display("FAIL b2b_stall1: got %b want 0", stall); end
      @(negedge clk);
      checks++;
      if (fwd_sel !== 4'b1010) begin errors++;
         $display("FAIL b2b_fwd: got %b want 1010", fwd_sel); end
      nop();
   endtask

   task automatic test_distance2();
      set_id(1, 0, 0, 2'b00, 7, 1, 0, 0, 0);
      @(negedge clk);
      set_id(1, 0, 0, 2'b00, 7, 1, 0, 0, 0);
      @(negedge clk);
      set_id(1, 7, 7, 2'b01, 11, 0, 0, 0, 0);
      #1;
      checks++;
      if (stall !== 1'b0) begin errors++;
         $display("FAIL d2_stall: got %b want 0", stall); end
      @(negedge clk);
      checks++;
      if (fwd_sel !== 4'b0010) begin errors++;
         $display("FAIL d2_ex_prio: got %b want 0010", fwd_sel); end
      drain();
      set_id(1, 0, 0, 2'b00, 7, 1, 0, 0, 0);
      @(negedge clk);
      set_id(1, 0, 0, 2'b00, 8, 1, 0, 0, 0);
      @(negedge clk);
      set_id(1, 7, 7, 2'b11, 11, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (fwd_sel !== 4'b0101) begin errors++;
         $display("FAIL d2_mem: got %b want 0101", fwd_sel); end
      nop();
   endtask

   task automatic test_load_use();
      set_id(1, 0, 1, 2'b01, 4, 1, 1, 0, 0);
      #1;
      checks++;
      if (stall !== 1'b0) begin errors++;
         $display("FAIL lu_lw_stall: got %b want 0", stall); end
      @(negedge clk);
      set_id(1, 0, 4, 2'b11, 6, 1, 0, 0, 0);
      #1;
      checks++;
      if (stall !== 1'b1) begin errors++;
         $display("FAIL lu_stall: got %b want 1", stall); end
      @(negedge clk);
      checks++;
      if (fwd_sel !== 4'b0000) begin errors++;
         $display("FAIL lu_fwd_bubble: got %b want 0000", fwd_sel); end
      #1;
      checks++;
      if (stall !== 1'b0) begin errors++;
         $display("FAIL lu_retry_stall: got %b want 0", stall); end
      @(negedge clk);
      checks++;
      if (fwd_sel !== 4'b0001) begin errors++;
         $display("FAIL lu_retry_fwd: got %b want 0001", fwd_sel); end
      set_id(1, 0, 6, 2'b01, 12, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (fwd_sel !== 4'b0010) begin errors++;
         $display("FAIL lu_after_fwd: got %b want 0010", fwd_sel); end
      nop();
   endtask

   task automatic test_mul();
      set_id(1, 2, 1, 2'b11, 9, 1, 0, 1, 0);
      #1;
      checks++;
      if (stall !== 1'b0 || mul_busy !== 1'b0) begin errors++;
         $display("FAIL mul_issue: got %b%b want 00",
                  stall, mul_busy); end
      @(negedge clk);
      set_id(1, 0, 9, 2'b01, 10, 1, 0, 0, 0);
      #1;
      checks++;
      if (fwd_sel !== 4'b0000) begin errors++;
         $display("FAIL mul_fwd_t1: got %b want 0000", fwd_sel); end
      checks++;
      if (stall !== 1'b1 || mul_busy !== 1'b1) begin errors++;
         $display("FAIL mul_t1: got %b%b want 11", stall, mul_busy); end
      for (int i = 2; i <= 3; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (stall !== 1'b1 || mul_busy !== 1'b1) begin errors++;
            $display("FAIL mul_t%0d: got %b%b want 11",
                     i, stall, mul_busy); end
      end
      @(negedge clk);
      #1;
      checks++;
      if (stall !== 1'b0 || mul_busy !== 1'b0) begin errors++;
         $display("FAIL mul_t4: got %b%b want 00", stall, mul_busy); end
      @(negedge clk);
      checks++;
      if (fwd_sel !== 4'b0000) begin errors++;
         $display("FAIL mul_reader_fwd: got %b want 0000", fwd_sel); end
      nop();
   endtask

   task automatic test_mul_stall_flush();
      set_id(1, 0, 0, 2'b00, 9, 1, 0, 1, 1);
      #1;
      checks++;
      if (stall !== 1'b0) begin errors++;
         $display("FAIL mf_flush_stall: got %b want 0", stall); end
      @(negedge clk);
      checks++;
      if (mul_busy !== 1'b0) begin errors++;
         $display("FAIL mf_flushed_start: got %b want 0", mul_busy); end
      set_id(1, 0, 1, 2'b01, 4, 1, 1, 0, 0);
      @(negedge clk);
      set_id(1, 0, 4, 2'b01, 9, 1, 0, 1, 0);
      #1;
      checks++;
      if (stall !== 1'b1) begin errors++;
         $display("FAIL mf_lu_stall: got %b want 1", stall); end
      @(negedge clk);
      #1;
      checks++;
      if (mul_busy !== 1'b0 || stall !== 1'b0) begin errors++;
         $display("FAIL mf_stalled_start: got %b%b want 00",
                  mul_busy, stall); end
      @(negedge clk);
      checks++;
      if (mul_busy !== 1'b1) begin errors++;
         $display("FAIL mf_start: got %b want 1", mul_busy); end
      set_id(0, 0, 0, 2'b00, 0, 0, 0, 0, 1);
      @(negedge clk);
      checks++;
      if (mul_busy !== 1'b1) begin errors++;
         $display("FAIL mf_flush_keep: got %b want 1", mul_busy); end
      nop();
      @(negedge clk);
      checks++;
      if (mul_busy !== 1'b1) begin errors++;
         $display("FAIL mf_last: got %b want 1", mul_busy); end
      @(negedge clk);
      checks++;
      if (mul_busy !== 1'b0) begin errors++;
         $display("FAIL mf_done: got %b want 0", mul_busy); end
   endtask

   task automatic test_r0_flush();
      set_id(1, 0, 0, 2'b00, 0, 1, 0, 0, 0);
      @(negedge clk);
      set_id(1, 0, 0, 2'b11, 13, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (fwd_sel !== 4'b0000) begin errors++;
         $display("FAIL r0_fwd: got %b want 0000", fwd_sel); end
      drain();
      set_id(1, 0, 1, 2'b01, 4, 1, 1, 0, 0);
      @(negedge clk);
      set_id(1, 0, 4, 2'b11, 6, 1, 0, 0, 1);
      #1;
      checks++;
      if (stall !== 1'b0) begin errors++;
         $display("FAIL fl_stall: got %b want 0", stall); end
      @(negedge clk);
      checks++;
      if (fwd_sel !== 4'b0000) begin errors++;
         $display("FAIL fl_fwd: got %b want 0000", fwd_sel); end
      set_id(1, 4, 6, 2'b11, 14, 0, 0, 0, 0);
      #1;
      checks++;
      if (stall !== 1'b0) begin errors++;
         $display("FAIL fl_next_stall: got %b want 0", stall); end
      @(negedge clk);
      checks++;
      if (fwd_sel !== 4'b0100) begin errors++;
         $display("FAIL fl_bubble_fwd: got %b want 0100", fwd_sel); end
      nop();
   endtask

   task automatic test_reset_mid_mul();
      set_id(1, 0, 0, 2'b00, 9, 1, 0, 1, 0);
      @(negedge clk);
      nop();
      @(negedge clk);
      set_id(1, 0, 9, 2'b01, 10, 1, 0, 0, 0);
      #1;
      checks++;
      if (stall !== 1'b1 || mul_busy !== 1'b1) begin errors++;
         $display("FAIL rm_pre: got %b%b want 11", stall, mul_busy); end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (mul_busy !== 1'b0 || stall !== 1'b0) begin errors++;
         $display("FAIL rm_async: got %b%b want 00", mul_busy, stall); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0 || mul_busy !== 1'b0) begin errors++;
         $display("FAIL rm_after: got %b%b want 00", stall, mul_busy); end
      @(negedge clk);
      checks++;
      if (fwd_sel !== 4'b0000) begin errors++;
         $display("FAIL rm_fwd: got %b want 0000", fwd_sel); end
      nop();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_back_to_back();
      drain();
      test_distance2();
      drain();
      test_load_use();
      drain();
      test_mul();
      drain();
      test_mul_stall_flush();
      drain();
      test_r0_flush();
      drain();
      test_reset_mid_mul();
      drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
